audio_rec_play_sequencer: RTL
=============================

// Module: audio_rec_play_sequencer
// PURPOSE
//  Sequences the shared sample memory and the Audio_Controller FIFO handshakes for record,
//  playback and live pass-through. Sits between the codec controller, the 32-bit {L,R}
//  sample memory and the equalizer filter, replacing the ad-hoc top-level record/play FSM.
//  One owner of mem address/wren and read/write strobes; filter output feeds the DAC path.
// PARAMETERS
//  ADDR_W     16  memory address width; depth = 2**ADDR_W samples
//  REPLICATE  3   memory writes per captured codec sample (write path runs at 1/3 rate)
//  MEM_LAT    2   cycles from mem_addr change to valid filt_sample
// PORTS
//  clk                 in   1       system clock (50 MHz)
//  rst                 in   1       asynchronous reset, active-low
//  rec_req             in   1       1-cycle pulse: start recording (debounced, release edge)
//  play_req            in   1       1-cycle pulse: start playback
//  stop_req            in   1       1-cycle pulse: abort record/playback
//  passthru_en         in   1       1 = live pass-through while IDLE
//  audio_in_available  in   1       codec input FIFO has a sample
//  audio_out_allowed   in   1       codec output FIFO has space
//  filt_sample         in   32      {L,R} filtered memory read data
//  read_audio_in       out  1       pop codec input FIFO
//  write_audio_out     out  1       push codec output FIFO
//  mem_addr            out  ADDR_W  memory address
//  mem_wren            out  1       memory write enable
//  out_sample          out  32      {L,R} sample for DAC when playing=1
//  playing             out  1       1 = DAC mux selects out_sample, else live input
//  rec_len             out  ADDR_W+1 samples stored by last recording (0..2**ADDR_W)
//  state               out  3       FSM state for LEDs
// BEHAVIOUR
//  - Reset (any time, mid-operation included): all outputs 0, rec_len 0, state IDLE.
//  - States: IDLE=0, REC_WAIT=1, REC_POP=2, REC_WR=3, PLAY_WAIT=4, PLAY_FETCH=5, PLAY_OUT=6.
//  - Request priority same cycle: stop > rec > play. Requests outside IDLE ignored except stop.
//  - IDLE: mem_wren=0, playing=0, mem_addr=0. If passthru_en and avail&allowed: registered
//    1-cycle pulse on both read_audio_in and write_audio_out, then >=1 cycle low before next.
//    rec_req -> REC_WAIT, rec_len<=0. play_req with rec_len!=0 -> PLAY_WAIT; rec_len==0 ignored.
//  - REC_WAIT: on avail&allowed -> REC_POP; stop_req here -> IDLE, rec_len<=mem_addr.
//  - REC_POP: read_audio_in=1 for exactly 1 cycle; -> REC_WR.
//  - REC_WR: REPLICATE consecutive cycles mem_wren=1, mem_addr+1 after each write.
//    stop_req during REC_POP/REC_WR is held and honoured on return to REC_WAIT (burst completes).
//    Writing last address (2**ADDR_W-1): burst truncates, rec_len<=2**ADDR_W, -> IDLE, no wrap.
//    Otherwise after burst -> REC_WAIT, rec_len tracks mem_addr.
//  - PLAY_WAIT: playing=1; on avail&allowed -> PLAY_FETCH. stop_req -> IDLE, playing<=0.
//  - PLAY_FETCH: hold mem_addr MEM_LAT cycles; -> PLAY_OUT.
//  - PLAY_OUT: out_sample<=filt_sample, write_audio_out=1 for 1 cycle, read_audio_in=1 same
//    cycle (drain input FIFO), mem_addr+1. If mem_addr==rec_len-1 -> IDLE (playing<=0),
//    else -> PLAY_WAIT. out_sample holds last value until next PLAY_OUT or reset.
//  - Strobes never asserted 2 consecutive cycles; mem_wren never high outside REC_WR.
//  - Sample latency playback: avail&allowed to write_audio_out = MEM_LAT+2 cycles.
// CONFIGURATION
//  LOOP_PLAYBACK_EN defined: at end of recording in PLAY_OUT, mem_addr<=0 and -> PLAY_WAIT;
//    playback repeats until stop_req. Undefined: single pass, return to IDLE.
// TESTING
//  1 Reset mid-REC_WR (mem_wren=1) -> same cycle mem_wren=0, state=0, rec_len=0.
//  2 rec_req, 4 avail&allowed events, stop_req -> 12 writes at addr 0..11, rec_len=12, IDLE.
//  3 rec_len=12, play_req, 4 events -> 4 write_audio_out pulses, addr 0..3 each
//    MEM_LAT+2 cycles after event; continue -> IDLE after addr 11, playing=0.
//  4 ADDR_W=4 record to full -> 16 writes, rec_len=16, no wrap, IDLE; no further wren.
//  5 play_req with rec_len=0 -> stays IDLE; rec_req+play_req+stop_req same cycle -> IDLE.
//  6 LOOP_PLAYBACK_EN, rec_len=3 -> addr sequence 0,1,2,0,1 then stop_req -> IDLE.

Source files
------------

// File: rtl/audio_rec_play_sequencer_if.sv
// Codec FIFO handshake and sample-memory bus between the record/play sequencer
// (master) and the codec / memory / equalizer side (slave).
interface audio_rec_play_sequencer_if #(
   parameter int ADDR_W = 16
);
   logic              audio_in_available;
   logic              audio_out_allowed;
   logic              read_audio_in;
   logic              write_audio_out;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wren;
   logic [31:0]       filt_sample;
   logic [31:0]       out_sample;
   logic              playing;

   modport master (
      input  audio_in_available, audio_out_allowed, filt_sample,
      output read_audio_in, write_audio_out, mem_addr, mem_wren, out_sample, playing
   );

   modport slave (
      output audio_in_available, audio_out_allowed, filt_sample,
      input  read_audio_in, write_audio_out, mem_addr, mem_wren, out_sample, playing
   );
endinterface

// File: rtl/audio_rec_play_sequencer.sv
// Record / playback / live pass-through sequencer; sole owner of mem address, wren and codec strobes.
// Build option LOOP_PLAYBACK_EN: playback wraps to address 0 and repeats until stop_req.
module audio_rec_play_sequencer #(
   parameter int ADDR_W    = 16,
   parameter int REPLICATE = 3,
   parameter int MEM_LAT   = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_rec_req,
   input  logic                      i_play_req,
   input  logic                      i_stop_req,
   input  logic                      i_passthru_en,
   audio_rec_play_sequencer_if.master bus,
   output logic [ADDR_W:0]           o_rec_len,
   output logic [2:0]                o_state
);
   localparam int CNT_MAX = (REPLICATE > MEM_LAT) ? REPLICATE : MEM_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [ADDR_W:0] ONE = 1;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_REC_WAIT   = 3'd1,
      S_REC_POP    = 3'd2,
      S_REC_WR     = 3'd3,
      S_PLAY_WAIT  = 3'd4,
      S_PLAY_FETCH = 3'd5,
      S_PLAY_OUT   = 3'd6
   } state_t;

   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_rec_len;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_stop_pend;
   logic              r_strobe;
   logic [31:0]       r_out;

   logic w_av, w_stop, w_addr_max, w_last, w_burst_done, w_fetch_done, w_pt_fire;

   assign w_av         = bus.audio_in_available & bus.audio_out_allowed;
   assign w_stop       = i_stop_req | r_stop_pend;
   assign w_addr_max   = &r_addr;
   assign w_last       = (({1'b0, r_addr} + ONE) == r_rec_len);
   assign w_burst_done = (r_cnt == CNT_W'(REPLICATE - 1));
   assign w_fetch_done = (r_cnt == CNT_W'(MEM_LAT - 1));

   // Pass-through only fires when staying idle and the previous cycle had no strobe.
   assign w_pt_fire = (r_state == S_IDLE) && (w_next == S_IDLE) && i_passthru_en && w_av && !r_strobe;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (!i_stop_req) begin
               if (i_rec_req)                             w_next = S_REC_WAIT;
               else if (i_play_req && (r_rec_len != '0))  w_next = S_PLAY_WAIT;
            end
         end
         S_REC_WAIT: begin
            if (w_stop)      w_next = S_IDLE;
            else if (w_av)   w_next = S_REC_POP;
         end
         S_REC_POP:          w_next = S_REC_WR;
         S_REC_WR: begin
            if (w_addr_max)        w_next = S_IDLE;
            else if (w_burst_done) w_next = S_REC_WAIT;
         end
         S_PLAY_WAIT: begin
            if (w_stop)      w_next = S_IDLE;
            else if (w_av)   w_next = S_PLAY_FETCH;
         end
         S_PLAY_FETCH: begin
            if (w_fetch_done) w_next = S_PLAY_OUT;
         end
         S_PLAY_OUT: begin
`ifdef LOOP_PLAYBACK_EN
            w_next = S_PLAY_WAIT;
`else
            w_next = w_last ? S_IDLE : S_PLAY_WAIT;
`endif
         end
         default:            w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.read_audio_in   = r_strobe;
      bus.write_audio_out = r_strobe;
      bus.mem_wren        = 1'b0;
      bus.playing         = 1'b0;
      case (r_state)
         S_REC_POP:                             bus.read_audio_in = 1'b1;
         S_REC_WR:                              bus.mem_wren      = 1'b1;
         S_PLAY_WAIT, S_PLAY_FETCH, S_PLAY_OUT: bus.playing       = 1'b1;
         default: ;
      endcase
   end

   assign bus.mem_addr   = r_addr;
   assign bus.out_sample = r_out;
   assign o_rec_len      = r_rec_len;
   assign o_state        = r_state;

   // Playback strobe is registered out of PLAY_OUT so it lines up with the captured sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr      <= '0;
         r_rec_len   <= '0;
         r_cnt       <= '0;
         r_stop_pend <= 1'b0;
         r_strobe    <= 1'b0;
         r_out       <= '0;
      end else begin
         r_strobe    <= (r_state == S_PLAY_OUT) | w_pt_fire;
         r_cnt       <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
         r_stop_pend <= (w_next == S_IDLE) ? 1'b0 : (r_stop_pend | i_stop_req);
         case (r_state)
            S_IDLE: begin
               if (w_next == S_REC_WAIT) r_rec_len <= '0;
            end
            S_REC_WAIT: begin
               if (w_stop) r_rec_len <= {1'b0, r_addr};
            end
            S_REC_WR: begin
               r_rec_len <= {1'b0, r_addr} + ONE;
               r_addr    <= r_addr + 1'b1;
            end
            S_PLAY_OUT: begin
               r_out  <= bus.filt_sample;
               r_addr <= w_last ? '0 : r_addr + 1'b1;
            end
            default: ;
         endcase
         if (w_next == S_IDLE) r_addr <= '0;
      end
   end
endmodule
